// File: rtl/reg_file_8x32.sv
// 8 x 32-bit processor register file: two combinational operand read ports and
// one write-back port. Register 0 reads as zero, and same-cycle writes forward to the read ports.
module reg_file_8x32 #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3,
  parameter int NREGS  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack
);

  // Register 0 has no storage; only 1..NREGS-1 exist.
  logic [DATA_W-1:0] r_regs [1:NREGS-1];
  logic              r_wr_ack;
  logic              w_wr_commit;
  logic [ADDR_W-1:0] w_rd_addr [2];
  logic [DATA_W-1:0] w_rd_data [2];

  // Gating with rst_n keeps the forwarded value out of the read ports during reset.
  assign w_wr_commit = rst_n && wr_en && (wr_addr != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NREGS; i++) r_regs[i] <= '0;
      r_wr_ack <= 1'b0;
    end else begin
      if (w_wr_commit) r_regs[wr_addr] <= wr_data;
      r_wr_ack <= w_wr_commit;
    end
  end

  assign w_rd_addr[0] = rd_addr_a;
  assign w_rd_addr[1] = rd_addr_b;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      always_comb begin
        if (w_rd_addr[gi] == '0)
          w_rd_data[gi] = '0;
        else if (w_wr_commit && (wr_addr == w_rd_addr[gi]))
          w_rd_data[gi] = wr_data;
        else
          w_rd_data[gi] = r_regs[w_rd_addr[gi]];
      end
    end
  endgenerate

  assign rd_data_a = w_rd_data[0];
  assign rd_data_b = w_rd_data[1];
  assign wr_ack    = r_wr_ack;

endmodule
